ssd_mux_driver: RTL

Parametrised, time-multiplexed N-digit hexadecimal seven-segment display driver. It replaces the fixed four-digit driver in the display path. Added behaviour:
- Configurable digit count, refresh rate and drive polarity.
- Per-digit decimal points.
- Tear-free frame latching of display data.
- Anti-ghosting guard interval.
- Optional leading-zero blanking.

It sits between the system data/status registers and the board SSD pins.

---
 rtl/ssd_mux_driver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-latched display data.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module ssd_mux_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 0,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] DataIn,
  input  logic [NUM_DIGITS-1:0]   DP_In,
  output logic [6:0]              SSD_Out,
  output logic                    SSD_DP,
  output logic [NUM_DIGITS-1:0]   SSD_Select
);

  localparam int unsigned PcW  = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PcW-1:0]        PcLast  = PcW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]       IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]            PolSeg  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] PolSel  = ACTIVE_LOW ? '1 : '0;
  localparam logic                  PolDp   = ACTIVE_LOW;

  logic [PcW-1:0]          pc_q, pc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    en_d_q;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  logic                    start;
  logic                    pc_wrap;
  logic                    frame_wrap;
  logic                    in_guard;
  logic [4*NUM_DIGITS-1:0] view_data;
  logic [NUM_DIGITS-1:0]   view_dp;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   sel_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [PcW-1:0] GuardEnd = PcW'(GUARD_CYCLES);
      assign in_guard = (pc_q < GuardEnd);
    end
  endgenerate

  assign start      = En && !en_d_q;
  assign pc_wrap    = (pc_q == PcLast);
  assign frame_wrap = pc_wrap && (idx_q == IdxLast);

  always_comb begin
    pc_d          = '0;
    idx_d         = '0;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (En) begin
      pc_d  = pc_wrap ? '0 : pc_q + PcW'(1);
      idx_d = idx_q;
      if (pc_wrap) begin
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
      if (start || frame_wrap) begin
        shadow_data_d = DataIn;
        shadow_dp_d   = DP_In;
      end
    end
  end

  // On the enable-start cycle the shadow is still loading; show the incoming data directly.
  assign view_data = start ? DataIn : shadow_data_q;
  assign view_dp   = start ? DP_In : shadow_dp_q;

  always_comb begin
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      nib[k] = view_data[4*k +: 4];
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run && (nib[k] == 4'h0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    sel_d = '0;
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (En && !in_guard) begin
      sel_d[idx_q] = 1'b1;
      seg_d        = blank[idx_q] ? 7'h00 : hex_to_seg(nib[idx_q]);
      dp_d         = view_dp[idx_q];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q          <= '0;
      idx_q         <= '0;
      en_d_q        <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      SSD_Out       <= PolSeg;
      SSD_DP        <= PolDp;
      SSD_Select    <= PolSel;
    end else begin
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      en_d_q        <= En;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      SSD_Out       <= seg_d ^ PolSeg;
      SSD_DP        <= dp_d ^ PolDp;
      SSD_Select    <= sel_d ^ PolSel;
    end
  end

endmodule
